aes_key_schedule_seq: RTL and testbench

//  Sequential multi-length AES key schedule that emits round keys in order.

---
 rtl/aes_key_schedule_seq_pkg.sv | 47 ++++
 rtl/aes_key_schedule_seq_if.sv | 30 +++
 rtl/aes_key_schedule_seq_sub_word.sv | 35 +++
 rtl/aes_key_schedule_seq.sv | 178 +++++++++++++++++
 tb/tb_aes_key_schedule_seq.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_schedule_seq_pkg.sv
// Shared types, constants and helpers for the sequential AES key schedule.
package aes_key_schedule_seq_pkg;

  typedef enum logic [1:0] {
    KeyLen128 = 2'd0,
    KeyLen192 = 2'd1,
    KeyLen256 = 2'd2,
    KeyLenBad = 2'd3
  } key_len_e;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  localparam logic [7:0] AES_RCON0 = 8'h01;

  // Number of 32-bit key words for a key length encoding (0 when illegal).
  function automatic logic [3:0] nk_of(input logic [1:0] key_len);
    case (key_len)
      2'd0:    return 4'd4;
      2'd1:    return 4'd6;
      2'd2:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  // Number of rounds for a key length encoding (0 when illegal).
  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      2'd0:    return 4'd10;
      2'd1:    return 4'd12;
      2'd2:    return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// Control and round-key stream bundle between the key schedule and its user.
interface aes_key_schedule_seq_if #(
  parameter int unsigned KEY_W   = 256,
  parameter int unsigned ROUND_W = 4
) ();

  logic               start;
  logic [1:0]         key_len;
  logic [KEY_W-1:0]   key;
  logic               abort;
  logic [127:0]       rk_data;
  logic [ROUND_W-1:0] rk_round;
  logic               rk_last;
  logic               rk_valid;
  logic               rk_ready;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, key_len, key, abort, rk_ready,
    input  rk_data, rk_round, rk_last, rk_valid, busy, done, err
  );

  modport slave (
    input  start, key_len, key, abort, rk_ready,
    output rk_data, rk_round, rk_last, rk_valid, busy, done, err
  );

endinterface

// File: rtl/aes_key_schedule_seq_sub_word.sv
// SubWord: four parallel combinational AES S-box lookups.
module aes_sub_word (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  // Byte x lives at bits [(255-x)*8 +: 8], i.e. entry 0 is the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // One S-box lookup per byte lane.
  always_comb begin
    o_word = '0;
    for (int b = 0; b < 4; b++) begin
      o_word[8*b +: 8] = SBOX_TABLE[{~i_word[8*b +: 8], 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key schedule: one schedule word per clock,
// grouped four at a time into 128-bit round keys on a valid/ready stream.
module aes_key_schedule_seq
  import aes_key_schedule_seq_pkg::*;
#(
  parameter int unsigned KEY_W   = 256,
  parameter int unsigned ROUND_W = 4
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  aes_key_schedule_seq_if.slave  rk_if
);

  state_e             r_state, w_state_nxt;
  logic [31:0]        r_win [8];   // r_win[k] holds w[i-1-k]
  logic [31:0]        r_buf [3];   // words 0..2 of the current round key
  logic [5:0]         r_cnt;       // schedule word index i
  logic [2:0]         r_kcnt;      // i mod Nk
  logic [7:0]         r_rcon;
  logic [3:0]         r_nk, r_nr;
  logic [1:0]         r_col;
  logic [ROUND_W-1:0] r_round;
  logic [127:0]       r_rk_data;
  logic [ROUND_W-1:0] r_rk_round;
  logic               r_rk_last, r_rk_valid, r_done, r_err;

  logic [31:0] w_key_word [8];
  logic [31:0] w_win_load [8];
  logic [31:0] w_old, w_sub_in, w_sub_out, w_new;
  logic [3:0]  w_nk_in;
  logic [5:0]  w_total;
  logic [2:0]  w_kcnt_max;
  logic        w_legal, w_accept, w_err_pulse, w_gen, w_load_slot, w_step, w_load;
  logic        w_hs, w_last_hs, w_is_rcon_step, w_pre_key;

  // Split the MSB-aligned key into words; words beyond KEY_W read as zero.
  for (genvar j = 0; j < 8; j++) begin : g_key_word
    if (j < KEY_W / 32) begin : g_used
      assign w_key_word[j] = rk_if.key[KEY_W-1-32*j -: 32];
    end else begin : g_unused
      assign w_key_word[j] = '0;
    end
  end

  assign w_nk_in     = nk_of(rk_if.key_len);
  assign w_legal     = (rk_if.key_len != KeyLenBad) && ((32'(w_nk_in) * 32) <= KEY_W);
  assign w_accept    = (r_state == StIdle) && rk_if.start && !rk_if.abort && w_legal;
  assign w_err_pulse = (r_state == StIdle) && rk_if.start && !rk_if.abort && !w_legal;

  assign w_total        = {r_nr + 4'd1, 2'b00};
  assign w_gen          = r_cnt < w_total;
  assign w_load_slot    = (r_col == 2'd3);
  assign w_hs           = r_rk_valid && rk_if.rk_ready;
  assign w_step         = (r_state == StRun) && !rk_if.abort && w_gen &&
                          (!w_load_slot || !r_rk_valid || rk_if.rk_ready);
  assign w_load         = w_step && w_load_slot;
  assign w_last_hs      = (r_state == StRun) && !rk_if.abort && w_hs && r_rk_last;
  assign w_pre_key      = r_cnt < {2'b00, r_nk};
  assign w_is_rcon_step = !w_pre_key && (r_kcnt == 3'd0);
  assign w_kcnt_max     = 3'(r_nk - 4'd1);

  // The key is preloaded so that w[i-Nk] slot delivers key word i while i < Nk.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_win_load[k] = '0;
      if (4'(k) < w_nk_in) begin
        w_win_load[k] = w_key_word[3'(w_nk_in - 4'd1 - 4'(k))];
      end
    end
  end

  // Single SubWord unit shared by the rcon step and the AES-256 mid-group step.
  assign w_old    = r_win[3'(r_nk - 4'd1)];
  assign w_sub_in = (r_kcnt == 3'd0) ? rot_word(r_win[0]) : r_win[0];

  aes_sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  // Next schedule word w[i].
  always_comb begin
    w_new = w_old ^ r_win[0];
    if (w_pre_key) begin
      w_new = w_old;
    end else if (r_kcnt == 3'd0) begin
      w_new = w_old ^ w_sub_out ^ {r_rcon, 24'h0};
    end else if ((r_nk == 4'd8) && (r_kcnt == 3'd4)) begin
      w_new = w_old ^ w_sub_out;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  // FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_nxt = StRun;
      StRun:   if (rk_if.abort || w_last_hs) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Datapath: window, counters, collector and output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 8; k++) r_win[k] <= '0;
      for (int k = 0; k < 3; k++) r_buf[k] <= '0;
      r_cnt      <= '0;
      r_kcnt     <= '0;
      r_rcon     <= '0;
      r_nk       <= '0;
      r_nr       <= '0;
      r_col      <= '0;
      r_round    <= '0;
      r_rk_data  <= '0;
      r_rk_round <= '0;
      r_rk_last  <= 1'b0;
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= w_last_hs;
      r_err  <= w_err_pulse;
      if (w_accept) begin
        for (int k = 0; k < 8; k++) r_win[k] <= w_win_load[k];
        r_nk       <= w_nk_in;
        r_nr       <= nr_of(rk_if.key_len);
        r_cnt      <= '0;
        r_kcnt     <= '0;
        r_rcon     <= AES_RCON0;
        r_col      <= '0;
        r_round    <= '0;
        r_rk_valid <= 1'b0;
      end else if (r_state == StRun) begin
        if (rk_if.abort) begin
          r_rk_valid <= 1'b0;
        end else begin
          if (w_step) begin
            r_win[0] <= w_new;
            for (int k = 1; k < 8; k++) r_win[k] <= r_win[k-1];
            r_cnt  <= r_cnt + 6'd1;
            r_kcnt <= (r_kcnt == w_kcnt_max) ? 3'd0 : r_kcnt + 3'd1;
            if (w_is_rcon_step) r_rcon <= xtime(r_rcon);
            if (w_load_slot) begin
              r_rk_data  <= {r_buf[0], r_buf[1], r_buf[2], w_new};
              r_rk_round <= r_round;
              r_rk_last  <= (r_round == ROUND_W'(r_nr));
              r_round    <= r_round + ROUND_W'(1);
              r_col      <= '0;
            end else begin
              r_buf[0] <= r_buf[1];
              r_buf[1] <= r_buf[2];
              r_buf[2] <= w_new;
              r_col    <= r_col + 2'd1;
            end
          end
          if (w_load)    r_rk_valid <= 1'b1;
          else if (w_hs) r_rk_valid <= 1'b0;
        end
      end
    end
  end

  assign rk_if.rk_data  = r_rk_data;
  assign rk_if.rk_round = r_rk_round;
  assign rk_if.rk_last  = r_rk_last;
  assign rk_if.rk_valid = r_rk_valid;
  assign rk_if.busy     = (r_state == StRun);
  assign rk_if.done     = r_done;
  assign rk_if.err      = r_err;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench for aes_key_schedule_seq against a FIPS-197 reference model.
module tb_aes_key_schedule_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  aes_key_schedule_seq_if #(.KEY_W(256), .ROUND_W(4)) bus ();
  aes_key_schedule_seq_if #(.KEY_W(128), .ROUND_W(4)) bus128 ();

  aes_key_schedule_seq #(.KEY_W(256), .ROUND_W(4)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .rk_if   (bus)
  );

  aes_key_schedule_seq #(.KEY_W(128), .ROUND_W(4)) u_dut128 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .rk_if   (bus128)
  );

  // ---------------- reference model ----------------
  logic [7:0]   sbox_ref [256];
  logic [31:0]  w_ref [60];
  logic [127:0] rx_data [16];

  function automatic int gmul(input int a, input int b);
    int p = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if ((b >> i) & 1) p = p ^ x;
      x = x << 1;
      if (x & 'h100) x = x ^ 'h11b;
    end
    return p;
  endfunction

  function automatic int rotl8(input int b, input int n);
    return ((b << n) | (b >> (8 - n))) & 'hff;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      int inv = 1;
      int s;
      for (int e = 0; e < 254; e++) inv = gmul(inv, x);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 'h63;
      sbox_ref[x] = 8'(s);
    end
  endtask

  function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
    return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
  endfunction

  task automatic expand_ref(input int kl, input logic [255:0] k);
    int nk = 4 + 2 * kl;
    int nr = nk + 6;
    int rcon = 1;
    logic [31:0] t;
    for (int i = 0; i < nk; i++) w_ref[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w_ref[i-1];
      if (i % nk == 0) begin
        t = sub_word_ref((t << 8) | (t >> 24)) ^ (32'(rcon) << 24);
        rcon = gmul(rcon, 2);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word_ref(t);
      end
      w_ref[i] = w_ref[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] rk_ref(input int r);
    return {w_ref[4*r], w_ref[4*r+1], w_ref[4*r+2], w_ref[4*r+3]};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full run: start, drain all round keys with ready low low_pct% of cycles.
  task automatic run_key(input int kl, input logic [255:0] k, input int low_pct, input bit poke);
    int nr = 10 + 2 * kl;
    int n = 0;
    int first_v = -1;
    int last_v = -1;
    bit prev_stall = 0;
    bit err_seen = 0;
    bit fin = 0;
    logic [127:0] prev_data = '0;
    expand_ref(kl, k);
    @(negedge clk);
    bus.start = 1'b1; bus.key_len = 2'(kl); bus.key = k; bus.rk_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.key = rand256();
    check_eq("busy_after_start", 128'(bus.busy), 128'(1));
    for (int iter = 0; iter < 600 && !fin; iter++) begin
      @(negedge clk);
      if (bus.err) err_seen = 1;
      if (prev_stall) begin
        check_eq("stall_valid_held", 128'(bus.rk_valid), 128'(1));
        check_eq("stall_data_held", bus.rk_data, prev_data);
      end
      if (bus.rk_valid && first_v < 0) first_v = iter;
      bus.start    = poke && (iter == 6);
      bus.key_len  = (poke && iter == 6) ? 2'd3 : 2'(kl);
      bus.rk_ready = ($urandom_range(99) >= low_pct);
      if (bus.rk_valid && bus.rk_ready) begin
        if (n < 16) begin
          rx_data[n] = bus.rk_data;
          check_eq($sformatf("rk%0d_len%0d", n, kl), bus.rk_data, rk_ref(n));
        end
        check_eq($sformatf("round%0d", n), 128'(bus.rk_round), 128'(n));
        check_eq($sformatf("last%0d", n), 128'(bus.rk_last), 128'(n == nr));
        if (bus.rk_last) begin
          fin = 1;
          last_v = iter;
        end
        n++;
        prev_stall = 0;
      end else begin
        prev_stall = bus.rk_valid;
        prev_data  = bus.rk_data;
      end
    end
    bus.start = 1'b0;
    if (!fin) check_eq("run_timeout", 128'(0), 128'(1));
    @(negedge clk);
    bus.rk_ready = 1'b0;
    check_eq("done_pulse", 128'(bus.done), 128'(1));
    check_eq("busy_after_last", 128'(bus.busy), 128'(0));
    check_eq("valid_after_last", 128'(bus.rk_valid), 128'(0));
    @(negedge clk);
    check_eq("done_one_cycle", 128'(bus.done), 128'(0));
    check_eq("key_count", 128'(n), 128'(nr + 1));
    if (poke) check_eq("start_while_busy_no_err", 128'(err_seen), 128'(0));
    if (low_pct == 0) begin
      check_eq("latency_first", 128'(first_v), 128'(3));
      check_eq("latency_last", 128'(last_v), 128'(4 * (nr + 1) - 1));
    end
  endtask

  // Abort while round 5 is held un-accepted.
  task automatic run_abort();
    bit found = 0;
    int hold = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.key_len = 2'd0; bus.key = rand256();
    @(negedge clk);
    bus.start = 1'b0;
    for (int iter = 0; iter < 200 && !found; iter++) begin
      @(negedge clk);
      if (bus.rk_valid && bus.rk_round == 4'd5) begin
        bus.rk_ready = 1'b0;
        hold++;
        if (hold == 3) begin
          bus.abort = 1'b1;
          found = 1;
        end
      end else begin
        bus.rk_ready = 1'b1;
      end
    end
    check_eq("abort_reached_round5", 128'(found), 128'(1));
    @(negedge clk);
    bus.abort = 1'b0;
    check_eq("abort_valid_clear", 128'(bus.rk_valid), 128'(0));
    check_eq("abort_busy_clear", 128'(bus.busy), 128'(0));
    @(negedge clk);
    check_eq("abort_no_done", 128'(bus.done), 128'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    bus.start = 1'b0; bus.key_len = 2'd0; bus.key = '0; bus.abort = 1'b0; bus.rk_ready = 1'b0;
    bus128.start = 1'b0; bus128.key_len = 2'd0; bus128.key = '0;
    bus128.abort = 1'b0; bus128.rk_ready = 1'b0;
    rst_n = 1'b0;
    build_sbox();
    repeat (3) @(negedge clk);
    check_eq("reset_valid", 128'(bus.rk_valid), 128'(0));
    check_eq("reset_busy", 128'(bus.busy), 128'(0));
    check_eq("reset_done", 128'(bus.done), 128'(0));
    check_eq("reset_err", 128'(bus.err), 128'(0));
    check_eq("reset_data", bus.rk_data, 128'(0));
    check_eq("reset_round_last", 128'({bus.rk_round, bus.rk_last}), 128'(0));
    rst_n = 1'b1;

    // Known-answer vectors.
    run_key(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0, 0);
    check_eq("aes128_rk1", rx_data[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check_eq("aes128_rk10", rx_data[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_key(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 0, 0);
    check_eq("aes192_rk12", rx_data[12], 128'he98ba06f448c773c8ecc720401002202);
    run_key(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 0, 0);
    check_eq("aes256_rk14", rx_data[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Back-pressure with a start poked mid-run.
    run_key(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 30, 1);
    for (int kl = 0; kl < 3; kl++) run_key(kl, rand256(), 30, 0);

    // Abort, then a fresh run must still produce a correct schedule.
    run_abort();
    run_key(0, rand256(), 0, 0);

    // Illegal key length pulses err, stays idle.
    @(negedge clk);
    bus.start = 1'b1; bus.key_len = 2'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("err_len3", 128'(bus.err), 128'(1));
    check_eq("err_len3_busy", 128'(bus.busy), 128'(0));
    @(negedge clk);
    check_eq("err_len3_one_cycle", 128'(bus.err), 128'(0));

    // 128-bit instance rejects AES-256.
    bus128.start = 1'b1; bus128.key_len = 2'd2;
    @(negedge clk);
    bus128.start = 1'b0;
    check_eq("err_keyw128_len2", 128'(bus128.err), 128'(1));
    check_eq("err_keyw128_busy", 128'(bus128.busy), 128'(0));

    // start and abort together in idle: nothing starts.
    bus.start = 1'b1; bus.abort = 1'b1; bus.key_len = 2'd0;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0; bus.rk_ready = 1'b1;
    check_eq("start_abort_busy", 128'(bus.busy), 128'(0));
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rk_valid || bus.err) seen = 1;
    end
    check_eq("start_abort_quiet", 128'(seen), 128'(0));

    // Reset mid-run clears at once and leaves nothing behind.
    bus.start = 1'b1; bus.key_len = 2'd2; bus.key = rand256();
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrun_reset_valid", 128'(bus.rk_valid), 128'(0));
    check_eq("midrun_reset_busy", 128'(bus.busy), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rk_valid || bus.busy || bus.done) seen = 1;
    end
    check_eq("after_reset_quiet", 128'(seen), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
